// File: rtl/tl_rr_arbiter.sv
// Round-robin n-to-1 arbiter for valid/ready channels with burst locking.
// The one-hot grant drives downstream muxes; ready is returned to the winner only.
//
// state | meaning
// IDLE  | no offer held; grant follows the combinational round-robin pick
// PEND  | offer stalled by out_ready; grant frozen until the first beat fires
// BURST | multi-beat burst in flight; grant locked until the last beat fires
module tl_rr_arbiter #(
  parameter int n        = 4,
  parameter int width    = 32,
  parameter int beatBits = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [n-1:0]        in_valid,
  output logic [n-1:0]        in_ready,
  input  logic [width-1:0]    in_bits [n],
  input  logic [beatBits-1:0] in_len  [n],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [width-1:0]    out_bits,
  output logic                out_last,
  output logic [n-1:0]        grant
);

  localparam int pw = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, PEND, BURST} state_t;

  state_t              state, state_d;
  logic [n-1:0]        gnt_q, gnt_d, sel;
  logic [pw-1:0]       ptr, ptr_d, ptr_nx, sidx, gidx;
  logic [beatBits-1:0] cnt, cnt_d, len_q, len_d;
  logic                fire, found;

  // First valid requester scanning upward from ptr with wraparound.
  always_comb begin
    int j;
    sel   = '0;
    sidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < n; i++) begin
      j = (int'(ptr) + i) % n;
      if (!found && in_valid[j]) begin
        found   = 1'b1;
        sel[j]  = 1'b1;
        sidx    = pw'(j);
      end
    end
  end

  assign grant = (state == IDLE) ? sel : gnt_q;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < n; i++) begin
      if (grant[i]) gidx = pw'(i);
    end
  end

  assign out_valid = |(grant & in_valid);
  assign in_ready  = grant & {n{out_ready}};
  assign out_bits  = (grant == '0) ? '0 : in_bits[gidx];
  assign fire      = out_valid & out_ready;
  assign ptr_nx    = (gidx == pw'(n - 1)) ? '0 : gidx + pw'(1);

  always_comb begin
    if (state == BURST)   out_last = (cnt == len_q);
    else if (grant == '0) out_last = 1'b1;
    else                  out_last = (in_len[gidx] == '0);
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    ptr_d   = ptr;
    cnt_d   = cnt;
    len_d   = len_q;
    case (state)
      IDLE: begin
        if (fire) begin
          if (out_last) begin
            ptr_d = ptr_nx;
          end else begin
            state_d = BURST;
            gnt_d   = sel;
            len_d   = in_len[sidx];
            cnt_d   = beatBits'(1);
          end
        end else if (|in_valid) begin
          state_d = PEND;
          gnt_d   = sel;
        end
      end
      PEND: begin
        if (fire) begin
          if (out_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_nx;
          end else begin
            state_d = BURST;
            len_d   = in_len[gidx];
            cnt_d   = beatBits'(1);
          end
        end
      end
      BURST: begin
        // A dropped valid stalls here without counting a beat.
        if (fire) begin
          cnt_d = cnt + beatBits'(1);
          if (out_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      gnt_q <= '0;
      ptr   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_d;
      gnt_q <= gnt_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      len_q <= len_d;
    end
  end

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Directed bench for tl_rr_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_tl_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_bits [4];
  logic [2:0]  in_len  [4];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bits;
  logic        out_last;
  logic [3:0]  grant;

  int checks   = 0;
  int failures = 0;

  tl_rr_arbiter #(.n(4), .width(32), .beatBits(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .grant     (grant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_len[i] = 3'd0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_len[i] = 3'd0;
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_bits !== 32'd0) begin failures++; $display("FAIL rst_out_bits got=%h exp=0", out_bits); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL rst_out_last got=%b exp=1", out_last); end
    next_cycle();
    in_valid = 4'b1111;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL post_rst_grant got=%b exp=0001", grant); end
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=0001", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_rst_out_valid got=%b exp=1", out_valid); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      @(negedge clock);
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, grant, exp_g); end
      checks++; if (out_bits !== 32'hA0 + 32'(k % 4)) begin failures++; $display("FAIL rr_bits[%0d] got=%h exp=%h", k, out_bits, 32'hA0 + 32'(k % 4)); end
      checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL rr_last[%0d] got=%b exp=1", k, out_last); end
      next_cycle();
    end
  endtask

  task automatic test_burst_lock();
    logic [3:0] exp_g [6];
    logic       exp_l [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    in_len[1] = 3'd3;
    in_valid  = 4'b0111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++; if (grant !== exp_g[k]) begin failures++; $display("FAIL lock_grant[%0d] got=%b exp=%b", k, grant, exp_g[k]); end
      checks++; if (out_last !== exp_l[k]) begin failures++; $display("FAIL lock_last[%0d] got=%b exp=%b", k, out_last, exp_l[k]); end
      checks++; if (in_ready !== exp_g[k]) begin failures++; $display("FAIL lock_ready[%0d] got=%b exp=%b", k, in_ready, exp_g[k]); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    @(negedge clock);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_grant0 got=%b exp=0100", grant); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready0 got=%b exp=0000", in_ready); end
    next_cycle();
    in_valid = 4'b0101;
    for (int k = 1; k < 3; k++) begin
      @(negedge clock);
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_grant%0d got=%b exp=0100", k, grant); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid%0d got=%b exp=1", k, out_valid); end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_fire_grant got=%b exp=0100", grant); end
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL stall_fire_ready got=%b exp=0100", in_ready); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL stall_fire_last got=%b exp=1", out_last); end
    next_cycle();
    in_valid = 4'b0001;
    @(negedge clock);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL stall_after_grant got=%b exp=0001", grant); end
    next_cycle();
  endtask

  task automatic test_valid_drop();
    do_reset();
    in_len[3] = 3'd2;
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL drop_b1_grant got=%b exp=1000", grant); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL drop_b1_last got=%b exp=0", out_last); end
    next_cycle();
    in_valid = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_valid%0d got=%b exp=0", k, out_valid); end
      checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL drop_grant%0d got=%b exp=1000", k, grant); end
      checks++; if (dut.cnt !== 3'd1) begin failures++; $display("FAIL drop_cnt%0d got=%0d exp=1", k, dut.cnt); end
      next_cycle();
    end
    in_valid = 4'b1000;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin failures++; $display("FAIL drop_b2 got valid=%b last=%b exp valid=1 last=0", out_valid, out_last); end
    next_cycle();
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin failures++; $display("FAIL drop_b3 got valid=%b last=%b exp valid=1 last=1", out_valid, out_last); end
    next_cycle();
    in_valid = 4'b0000;
    @(negedge clock);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL drop_done_grant got=%b exp=0000", grant); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    in_len[0] = 3'd7;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (grant !== 4'b0001 || out_last !== 1'b0) begin failures++; $display("FAIL rmb_beat%0d got grant=%b last=%b exp grant=0001 last=0", k, grant, out_last); end
      next_cycle();
    end
    reset    = 1'b1;
    in_valid = 4'b0000;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rmb_grant got=%b exp=0000", grant); end
    checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL rmb_ptr got=%0d exp=0", dut.ptr); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL rmb_last got=%b exp=1", out_last); end
    next_cycle();
    in_len[0] = 3'd0;
    in_len[1] = 3'd1;
    in_valid  = 4'b0010;
    @(negedge clock);
    checks++; if (grant !== 4'b0010 || out_last !== 1'b0) begin failures++; $display("FAIL rmb_req1_b1 got grant=%b last=%b exp grant=0010 last=0", grant, out_last); end
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 4'b0010 || out_last !== 1'b1) begin failures++; $display("FAIL rmb_req1_b2 got grant=%b last=%b exp grant=0010 last=1", grant, out_last); end
    next_cycle();
    in_valid = 4'b0000;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_bits[i] = 32'hA0 + 32'(i);
      in_len[i]  = 3'd0;
    end
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_stall();
    test_valid_drop();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_rr_arbiter.md
# tl_rr_arbiter

Round-robin N-to-1 arbiter for TileLink-style valid/ready channels with multi-beat bursts. It generates the one-hot select that drives the cache's one-hot output muxes and returns ready to the chosen requester only. It sits upstream of the shared A-channel port and owns three things: fair requester selection, burst locking, and offer stability.

## Interface
- n, 4, number of requesters (≥2)
- width, 32, payload bits per requester
- beatBits, 3, width of burst length field; max burst = 2^beatBits beats
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  n  per-requester valid
- in_ready  output  n  per-requester ready; one-hot or zero
- in_bits  input  width×n (unpacked [n])  per-requester payload
- in_len  input  beatBits×n (unpacked [n])  burst length minus one; sampled on first beat
- out_valid  output  1  valid toward shared port
- out_ready  input  1  ready from shared port
- out_bits  output  width  payload of granted requester
- out_last  output  1  current beat is final beat of burst
- grant  output  n  one-hot granted requester (0 when none); feeds downstream one-hot muxes

## Operation
- State: FSM {IDLE, PEND, BURST}, grant register gnt_q[n], round-robin pointer ptr[clog2(n)], beat counter cnt[beatBits], latched length len_q[beatBits].
- Selection in IDLE: the first valid index scanning ptr, ptr+1, …, n-1, 0, …, ptr-1. Combinational result is sel.
- grant = (state==IDLE) ? sel : gnt_q. out_valid = |(grant & in_valid). out_bits = in_bits of the granted index, or 0 when grant==0.
- in_ready = grant & {n{out_ready}}. Handshake fire = out_valid & out_ready.
- out_last = (state==BURST) ? (cnt==len_q) : (in_len[granted]==0).
- IDLE: if any valid and !out_ready, go PEND and latch gnt_q=sel. If fire and out_last, the single-beat burst is complete; stay IDLE. If fire and !out_last, go BURST, set gnt_q=sel, len_q=in_len[sel], cnt=1.
- PEND: the offer is held and grant cannot change. On fire, if last go IDLE, else go BURST with len_q latched and cnt=1.
- BURST: on each fire, cnt+1. On a fire with cnt==len_q, go IDLE.
- Burst completion (fire with out_last, any state): ptr = winner index + 1, mod n.
- Requester rules: a requester in PEND or BURST must keep valid high. If it drops valid, out_valid falls, the FSM holds state and no beat is counted. Other requesters are never granted until the locked burst completes.
- Counter width: cnt wraps at 2^beatBits. len_q = 2^beatBits−1 is legal (full-length burst).

## Timing
- Reset values: state=IDLE, gnt_q=0, ptr=0, cnt=0, len_q=0. With all in_valid low after reset, out_valid=0, in_ready=0, grant=0, out_bits=0, out_last=1.
- Latency is zero cycles. Both in_valid→out_valid and out_ready→in_ready are combinational paths.
- No out_ready→grant path in PEND or BURST. In IDLE, grant depends only on in_valid and ptr.
- A burst of L+1 beats with out_ready held high occupies exactly L+1 cycles. The next burst may start the cycle after its last beat, so there are no bubbles.
- Simultaneous events:
  - Last-beat fire and new valids in the same cycle: the new arbitration uses the updated ptr from the next cycle.
  - Reset asserted mid-burst: returns to reset values at the next edge. The aborted burst is not resumed.

## Test plan
- Reset: hold reset 2 cycles with in_valid=4'b1111, then check the first cycle after release: grant=4'b0001, in_ready=4'b0001 (out_ready=1), out_valid=1. While reset is high, check outputs next edge = reset values.
- Round robin: all four valid, in_len=0, out_ready=1 for 8 cycles → grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Burst lock: req1 in_len=3, req0/2 valid, out_ready=1.
  - Granted req1 → grant=0010 for exactly 4 cycles, out_last=1 only on the 4th.
  - Next grant=0100.
- Stall stability: req2 valid alone, out_ready=0 for 3 cycles, then req0 asserts valid in cycle 2 → grant stays 0100 until out_ready=1 fires.
- Valid drop mid-burst: req3 in_len=2, after beat 1 drop valid 2 cycles → out_valid=0, cnt stays 1, grant=1000. Reassert → beats 2,3 complete, out_last on beat 3.
- Reset mid-burst: req0 in_len=7, assert reset after beat 3 → next cycle grant=0, ptr=0. Re-request from req1 only → grant=0010, out_last per its own in_len.
